down_timer: RTL and testbench

Loadable 24-bit down-counter with terminal-count strobe: the counting-down counterpart to the team's 24-bit up-counter (T-enabled, synchronously cleared, clocked on C). A value is loaded, then decremented once per cycle while T is high. The block pulses Z when the count reaches zero, and can optionally auto-reload to act as a programmable period generator or one-shot timer. It sits beside the up-counter in the board designs, driving LED blink rates and display-refresh ticks.

---
 rtl/down_timer.sv | 71 +++++++
 tb/tb_down_timer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counter with a one-cycle terminal-count strobe and optional auto-reload.
// It can act as a programmable period generator (AR=1) or as a one-shot timer (AR=0).
module down_timer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             C,
    input  logic             R,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             T,
    input  logic             AR,
    output logic [WIDTH-1:0] Q,
    output logic             Z,
    output logic             BUSY
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rl_q, rl_d;
    logic             z_q, z_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rl_d    = rl_q;
        z_d     = 1'b0;

        if (LD) begin
            // A load wins over any terminal event in the same cycle.
            q_d     = D;
            rl_d    = D;
            state_d = (D != '0) ? StRun : StIdle;
        end else if (state_q == StRun && T) begin
            if (q_q == One) begin
                z_d = 1'b1;
                if (AR) begin
                    q_d = rl_q;
                end else begin
                    q_d     = '0;
                    state_d = StIdle;
                end
            end else if (q_q != '0) begin
                // The zero guard keeps Q from wrapping to all-ones if RUN is ever reached with Q==0.
                q_d = q_q - One;
            end
        end
    end

    always_ff @(posedge C) begin
        if (!R) begin
            state_q <= StIdle;
            q_q     <= '0;
            rl_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rl_q    <= rl_d;
            z_q     <= z_d;
        end
    end

    assign Q    = q_q;
    assign Z    = z_q;
    assign BUSY = (state_q == StRun);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed vector table, auto-reload sequences and
// randomized stimulus against a rule-level reference model.
module tb_down_timer;

    localparam int WIDTH = 24;

    logic             C;
    logic             R;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic             T;
    logic             AR;
    logic [WIDTH-1:0] Q;
    logic             Z;
    logic             BUSY;

    int tests;
    int fails;

    down_timer #(.WIDTH(WIDTH)) dut (
        .C    (C),
        .R    (R),
        .LD   (LD),
        .D    (D),
        .T    (T),
        .AR   (AR),
        .Q    (Q),
        .Z    (Z),
        .BUSY (BUSY)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    typedef struct {
        logic             r;
        logic             ld;
        logic [WIDTH-1:0] d;
        logic             t;
        logic             ar;
        logic [WIDTH-1:0] exp_q;
        logic             exp_z;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ld, input logic [WIDTH-1:0] d,
                       input logic t, input logic ar, input logic [WIDTH-1:0] eq,
                       input logic ez, input logic eb);
        vec_t v;
        v.r = r; v.ld = ld; v.d = d; v.t = t; v.ar = ar;
        v.exp_q = eq; v.exp_z = ez; v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic drive(input logic r, input logic ld, input logic [WIDTH-1:0] d,
                         input logic t, input logic ar);
        R = r; LD = ld; D = d; T = t; AR = ar;
    endtask

    // Reference model state: rule-level behaviour only.
    int unsigned m_q, m_rl;
    bit          m_run, m_z;

    task automatic model_step(input logic r, input logic ld, input logic [WIDTH-1:0] d,
                              input logic t, input logic ar);
        if (!r) begin
            m_q = 0; m_rl = 0; m_run = 0; m_z = 0;
        end else if (ld) begin
            m_q = d; m_rl = d; m_run = (d != 0); m_z = 0;
        end else if (m_run && t) begin
            if (m_q == 1) begin
                m_z = 1;
                if (ar) m_q = m_rl;
                else begin
                    m_q = 0;
                    m_run = 0;
                end
            end else begin
                m_q = m_q - 1;
                m_z = 0;
            end
        end else begin
            m_z = 0;
        end
    endtask

    initial begin
        int zcount;
        bit saw_ones;
        tests = 0;
        fails = 0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Reset with a load pending, then released idle.
        add(0, 1, 5, 0, 0, 0, 0, 0);
        add(0, 1, 5, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        // One-shot D=3.
        add(1, 1, 3, 1, 0, 3, 0, 1);
        add(1, 0, 0, 1, 0, 2, 0, 1);
        add(1, 0, 0, 1, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        // Enable gating.
        add(1, 1, 3, 0, 0, 3, 0, 1);
        add(1, 0, 0, 1, 0, 2, 0, 1);
        add(1, 0, 0, 0, 0, 2, 0, 1);
        add(1, 0, 0, 1, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 1, 0, 0, 1, 0);
        // Load at Q==1 suppresses Z; load of 0 mid-run goes idle.
        add(1, 1, 2, 1, 0, 2, 0, 1);
        add(1, 0, 0, 1, 0, 1, 0, 1);
        add(1, 1, 7, 1, 0, 7, 0, 1);
        add(1, 0, 0, 1, 0, 6, 0, 1);
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        // Reset at Q==1 aborts without Z.
        add(1, 1, 2, 1, 0, 2, 0, 1);
        add(1, 0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        // Full-width load.
        add(1, 1, 24'hFFFFFF, 1, 0, 24'hFFFFFF, 0, 1);
        add(1, 0, 0, 1, 0, 24'hFFFFFE, 0, 1);
        // Auto-reload period 1, then AR dropped ends it at the next terminal event.
        add(1, 1, 1, 1, 1, 1, 0, 1);
        add(1, 0, 0, 1, 1, 1, 1, 1);
        add(1, 0, 0, 1, 1, 1, 1, 1);
        add(1, 0, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].ld, vecs[i].d, vecs[i].t, vecs[i].ar);
            tick();
            check($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d_z", i), 32'(Z), 32'(vecs[i].exp_z));
            check($sformatf("vec%0d_busy", i), 32'(BUSY), 32'(vecs[i].exp_busy));
        end

        // Auto-reload N=4 for 20 cycles: Q walks 3,2,1,4,... and Z fires every 4th cycle.
        drive(1, 1, 4, 1, 1);
        tick();
        check("ar4_load_q", 32'(Q), 32'd4);
        drive(1, 0, 0, 1, 1);
        zcount = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("ar4_q%0d", k), 32'(Q), 32'(4 - (k % 4)));
            check($sformatf("ar4_z%0d", k), 32'(Z), 32'((k % 4) == 0));
            check($sformatf("ar4_busy%0d", k), 32'(BUSY), 32'd1);
            if (Z) zcount++;
        end
        check("ar4_pulses", 32'(zcount), 32'd5);

        // After expiry Q must sit at 0 and never wrap.
        drive(1, 1, 2, 1, 0);
        tick();
        drive(1, 0, 0, 1, 0);
        saw_ones = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (Q == 24'hFFFFFF) saw_ones = 1;
        end
        check("no_wrap_ones", 32'(saw_ones), 32'd0);
        check("no_wrap_q", 32'(Q), 32'd0);

        // Randomized run against the reference model.
        drive(0, 0, 0, 0, 0);
        tick();
        model_step(0, 0, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            logic r, ld, t, ar;
            logic [WIDTH-1:0] d;
            r  = ($urandom_range(0, 63) != 0);
            ld = ($urandom_range(0, 9) == 0);
            t  = ($urandom_range(0, 3) != 0);
            ar = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0:       d = '0;
                1:       d = 24'hFFFFFF;
                2:       d = WIDTH'($urandom);
                default: d = WIDTH'($urandom_range(1, 6));
            endcase
            drive(r, ld, d, t, ar);
            tick();
            model_step(r, ld, d, t, ar);
            check($sformatf("rnd%0d_q", k), 32'(Q), m_q);
            check($sformatf("rnd%0d_z", k), 32'(Z), 32'(m_z));
            check($sformatf("rnd%0d_busy", k), 32'(BUSY), 32'(m_run));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
